// File: rtl/vector_logic_pkg.sv
// Shared definitions for the element-wise vector logic stages (and/or/xor/nand).
// Holds the handshake FSM state encoding and common zero/one constants.
package vector_logic_pkg;

  typedef enum logic [1:0] {
    STARTER_STATE = 2'd0,
    INPUT_STATE   = 2'd1,
    ENDER_STATE   = 2'd2
  } state_t;

  localparam int unsigned PKG_CONTROL_SIZE = 64;
  localparam int unsigned PKG_DATA_SIZE    = 64;

  localparam logic [PKG_CONTROL_SIZE-1:0] ZERO_CONTROL = 64'd0;
  localparam logic [PKG_CONTROL_SIZE-1:0] ONE_CONTROL  = 64'd1;
  localparam logic [PKG_DATA_SIZE-1:0]    ZERO_DATA    = 64'd0;

endpackage

// File: rtl/vector_and_gate.sv
// Streaming element-wise AND of two vectors: requests each element pair,
// accepts A and B in either order, emits one registered result per pair.
module vector_and_gate
  import vector_logic_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic                    DATA_A_IN_ENABLE,
  input  logic                    DATA_B_IN_ENABLE,
  output logic                    DATA_ENABLE,
  output logic                    DATA_OUT_ENABLE,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);

  localparam logic [CONTROL_SIZE-1:0] CTRL_ZERO = CONTROL_SIZE'(ZERO_CONTROL);
  localparam logic [CONTROL_SIZE-1:0] CTRL_ONE  = CONTROL_SIZE'(ONE_CONTROL);
  localparam logic [DATA_SIZE-1:0]    DATA_ZERO = DATA_SIZE'(ZERO_DATA);

  state_t                  state_q, state_d;
  logic [CONTROL_SIZE-1:0] index_q, index_d;
  logic [CONTROL_SIZE-1:0] size_q, size_d;
  logic [DATA_SIZE-1:0]    a_q, a_d;
  logic [DATA_SIZE-1:0]    b_q, b_d;
  logic                    a_flag_q, a_flag_d;
  logic                    b_flag_q, b_flag_d;
  logic                    ready_q, ready_d;
  logic                    data_enable_q, data_enable_d;
  logic                    data_out_enable_q, data_out_enable_d;
  logic [DATA_SIZE-1:0]    data_out_q, data_out_d;

  // Incoming operand takes priority over the stored one so same-cycle arrival works.
  logic [DATA_SIZE-1:0] a_eff_s, b_eff_s;
  logic                 have_a_s, have_b_s;

  always_comb begin
    a_eff_s  = DATA_A_IN_ENABLE ? DATA_A_IN : a_q;
    b_eff_s  = DATA_B_IN_ENABLE ? DATA_B_IN : b_q;
    have_a_s = a_flag_q | DATA_A_IN_ENABLE;
    have_b_s = b_flag_q | DATA_B_IN_ENABLE;
  end

  always_comb begin
    state_d           = state_q;
    index_d           = index_q;
    size_d            = size_q;
    a_d               = a_q;
    b_d               = b_q;
    a_flag_d          = a_flag_q;
    b_flag_d          = b_flag_q;
    ready_d           = 1'b0;
    data_enable_d     = 1'b0;
    data_out_enable_d = 1'b0;
    data_out_d        = data_out_q;

    case (state_q)
      STARTER_STATE: begin
        if (START) begin
          if (SIZE_IN != CTRL_ZERO) begin
            size_d        = SIZE_IN;
            index_d       = CTRL_ZERO;
            data_enable_d = 1'b1;
            a_flag_d      = 1'b0;
            b_flag_d      = 1'b0;
            state_d       = INPUT_STATE;
          end else begin
            ready_d = 1'b1;
          end
        end else begin
          state_d = STARTER_STATE;
        end
      end
      INPUT_STATE: begin
        if (DATA_A_IN_ENABLE) begin
          a_d      = DATA_A_IN;
          a_flag_d = 1'b1;
        end else begin
          a_d = a_q;
        end
        if (DATA_B_IN_ENABLE) begin
          b_d      = DATA_B_IN;
          b_flag_d = 1'b1;
        end else begin
          b_d = b_q;
        end
        if (have_a_s && have_b_s) begin
          data_out_d        = a_eff_s & b_eff_s;
          data_out_enable_d = 1'b1;
          state_d           = ENDER_STATE;
        end else begin
          state_d = INPUT_STATE;
        end
      end
      ENDER_STATE: begin
        if (index_q == size_q - CTRL_ONE) begin
          ready_d = 1'b1;
          index_d = CTRL_ZERO;
          state_d = STARTER_STATE;
        end else begin
          index_d       = index_q + CTRL_ONE;
          a_flag_d      = 1'b0;
          b_flag_d      = 1'b0;
          data_enable_d = 1'b1;
          state_d       = INPUT_STATE;
        end
      end
      default: begin
        state_d = STARTER_STATE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q           <= STARTER_STATE;
      index_q           <= CTRL_ZERO;
      size_q            <= CTRL_ZERO;
      a_q               <= DATA_ZERO;
      b_q               <= DATA_ZERO;
      a_flag_q          <= 1'b0;
      b_flag_q          <= 1'b0;
      ready_q           <= 1'b0;
      data_enable_q     <= 1'b0;
      data_out_enable_q <= 1'b0;
      data_out_q        <= DATA_ZERO;
    end else begin
      state_q           <= state_d;
      index_q           <= index_d;
      size_q            <= size_d;
      a_q               <= a_d;
      b_q               <= b_d;
      a_flag_q          <= a_flag_d;
      b_flag_q          <= b_flag_d;
      ready_q           <= ready_d;
      data_enable_q     <= data_enable_d;
      data_out_enable_q <= data_out_enable_d;
      data_out_q        <= data_out_d;
    end
  end

  assign READY           = ready_q;
  assign DATA_ENABLE     = data_enable_q;
  assign DATA_OUT_ENABLE = data_out_enable_q;
  assign DATA_OUT        = data_out_q;

endmodule

// File: doc/vector_and_gate.md
# vector_and_gate

Sequential vector stage that computes the element-wise AND of two operand vectors streamed one element at a time, producing one registered result element per input pair. It sits in the computing/information/logic_gate group, directly upstream of the scalar logic gates and downstream of the NTM memory/controller streams. It owns the element handshake: it requests each element pair, accepts A and B in any order, emits the result, and signals completion of the vector.

## Interface
- DATA_SIZE, 64, width of one vector element.
- CONTROL_SIZE, 64, width of SIZE_IN and the element counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  begin a vector operation; sampled only in STARTER_STATE.
- READY  out  1  one-cycle pulse when the whole vector is done.
- DATA_A_IN_ENABLE  in  1  DATA_A_IN holds a valid element this cycle.
- DATA_B_IN_ENABLE  in  1  DATA_B_IN holds a valid element this cycle.
- DATA_ENABLE  out  1  one-cycle pulse requesting the next element pair.
- DATA_OUT_ENABLE  out  1  one-cycle pulse, DATA_OUT holds a new result element.
- SIZE_IN  in  CONTROL_SIZE  number of elements; captured on accepted START.
- DATA_A_IN  in  DATA_SIZE  operand A element.
- DATA_B_IN  in  DATA_SIZE  operand B element.
- DATA_OUT  out  DATA_SIZE  result element A & B.

## Operation
- Reset: state STARTER_STATE; READY, DATA_ENABLE, DATA_OUT_ENABLE = 0; DATA_OUT = 0; index, captured size, A/B registers and A/B-captured flags = 0.
- STARTER_STATE: on START with SIZE_IN != 0: latch SIZE_IN, index <= 0, DATA_ENABLE <= 1, clear flags, go INPUT_STATE. On START with SIZE_IN == 0: READY <= 1 for one cycle, stay. Operand enables ignored.
- INPUT_STATE: DATA_ENABLE returns to 0 after its single cycle. DATA_A_IN_ENABLE captures A and sets A flag; DATA_B_IN_ENABLE likewise for B. Repeated enable for an already-captured operand overwrites it (last value wins). When both operands are available (flag set or enable present this cycle, same-cycle arrival allowed), DATA_OUT <= A & B using the incoming value where its enable is high, DATA_OUT_ENABLE <= 1, go ENDER_STATE.
- ENDER_STATE: DATA_OUT_ENABLE returns to 0. If index == size-1: READY <= 1, index <= 0, go STARTER_STATE. Else index <= index+1, clear flags, DATA_ENABLE <= 1, go INPUT_STATE. Operand enables ignored.
- START outside STARTER_STATE ignored; SIZE_IN changes after capture ignored.
- DATA_OUT holds its last value between elements and after READY.
- Index comparison is unsigned, CONTROL_SIZE wide; no wrap occurs since index stops at size-1.
- RST mid-operation aborts immediately to reset values; no READY issued.

## Timing
- All outputs registered; no combinational input-to-output path.
- START at edge t -> DATA_ENABLE high in cycle t+1.
- Last operand enable sampled at edge t -> DATA_OUT/DATA_OUT_ENABLE valid in cycle t+1.
- Non-final element: DATA_ENABLE for the next element in cycle t+2.
- Final element: READY high in cycle t+2, accepts a new START from edge t+2's following cycle.
- Minimum throughput: one element per 3 cycles (enables arriving the cycle after DATA_ENABLE).
- SIZE_IN == 0: READY high the cycle after START.

## Structure
- Shared package vector_logic_pkg: state typedef (STARTER_STATE, INPUT_STATE, ENDER_STATE), ZERO_CONTROL, ONE_CONTROL, ZERO_DATA constants; reused by sibling vector_or/xor/nand stages.
- Single module; AND computed inline in the result register. No sub-module needed; a shared vector_logic_fsm is the natural factor-out once siblings exist.

## Test plan
- Reset mid-vector: RST during INPUT_STATE of element 1 of 4 -> all outputs 0 next cycle, no READY, fresh START works.
- SIZE_IN=3, A={FFFF0000, 0F0F0F0F, 12345678}, B={00FFFF00, FFFFFFFF, 0} same-cycle enables -> DATA_OUT {00FF0000, 0F0F0F0F, 0}, three DATA_OUT_ENABLE pulses, one READY after the third.
- SIZE_IN=2, A enable 2 cycles before B, then B before A -> results correct, DATA_OUT_ENABLE one cycle after the later operand.
- A enable twice (AAAA then 5555) before B=FFFF -> DATA_OUT 5555.
- SIZE_IN=0 with START -> READY next cycle, no DATA_ENABLE, no DATA_OUT_ENABLE.
- START and SIZE_IN changed to 9 during an active SIZE_IN=2 vector -> ignored; exactly 2 results then READY.
